// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: read-owner encoding
// and starvation counter width.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_DMA  = 2'd2
    } rd_owner_t;

    localparam int STARVE_W = 8;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU (absolute priority,
// no wait input) and a DMA master that only uses cycles the CPU leaves idle.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 8
) (
    input  logic          mclk,
    input  logic          puc_rst,
    input  logic [AW-1:0] cpu_dmem_addr,
    input  logic          cpu_dmem_cen,
    input  logic [15:0]   cpu_dmem_din,
    input  logic [1:0]    cpu_dmem_wen,
    output logic [15:0]   cpu_dmem_dout,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [1:0]    dma_we,
    input  logic [15:0]   dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [15:0]   dma_rdata,
    output logic          dma_starve,
    output logic [AW-1:0] dmem_addr,
    output logic          dmem_cen,
    output logic [15:0]   dmem_din,
    output logic [1:0]    dmem_wen,
    input  logic [15:0]   dmem_dout
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    logic                cpu_act;
    logic                gnt;
    logic [1:0]          dma_wen;
    rd_owner_t           rd_owner_reg;
    rd_owner_t           rd_owner_next;
    logic [15:0]         dma_rdata_reg;
    logic [STARVE_W-1:0] starve_cnt_reg;
    logic [STARVE_W-1:0] starve_cnt_next;

    // Reset gates both masters off the memory so no access happens in reset.
    assign cpu_act = ~puc_rst & ~cpu_dmem_cen;
    assign gnt     = ~puc_rst & cpu_dmem_cen & dma_req;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wen
            assign dma_wen[gi] = ~dma_we[gi];
        end
    endgenerate

    // Idle cycles keep the CPU address/data on the pins to avoid toggling.
    always_comb begin
        dmem_addr = cpu_dmem_addr;
        dmem_din  = cpu_dmem_din;
        dmem_wen  = 2'b11;
        dmem_cen  = 1'b1;
        if (cpu_act) begin
            dmem_cen = 1'b0;
            dmem_wen = cpu_dmem_wen;
        end else if (gnt) begin
            dmem_cen  = 1'b0;
            dmem_addr = dma_addr;
            dmem_din  = dma_wdata;
            dmem_wen  = dma_wen;
        end
    end

    always_comb begin
        rd_owner_next = RD_NONE;
        if (cpu_act && (cpu_dmem_wen == 2'b11)) begin
            rd_owner_next = RD_CPU;
        end else if (gnt && (dma_we == 2'b00)) begin
            rd_owner_next = RD_DMA;
        end
    end

    always_comb begin
        starve_cnt_next = '0;
        if (dma_req && !gnt) begin
            starve_cnt_next = (starve_cnt_reg == STARVE_LIMIT) ? starve_cnt_reg
                                                               : starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            rd_owner_reg   <= RD_NONE;
            dma_rdata_reg  <= 16'h0000;
            starve_cnt_reg <= '0;
        end else begin
            rd_owner_reg   <= rd_owner_next;
            starve_cnt_reg <= starve_cnt_next;
            if (rd_owner_reg == RD_DMA) begin
                dma_rdata_reg <= dmem_dout;
            end
        end
    end

    assign cpu_dmem_dout = dmem_dout;
    assign dma_gnt       = gnt;
    // A read in flight when reset hits must not produce a pulse.
    assign dma_rvalid    = ~puc_rst & (rd_owner_reg == RD_DMA);
    assign dma_rdata     = dma_rdata_reg;
    assign dma_starve    = (starve_cnt_reg == STARVE_LIMIT);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a table of combinational arbitration
// vectors followed by hand-written multi-cycle sequences against a memory model.
module tb_dmem_port_arbiter;

    logic        mclk;
    logic        puc_rst;
    logic [9:0]  cpu_dmem_addr;
    logic        cpu_dmem_cen;
    logic [15:0] cpu_dmem_din;
    logic [1:0]  cpu_dmem_wen;
    logic [15:0] cpu_dmem_dout;
    logic        dma_req;
    logic [9:0]  dma_addr;
    logic [1:0]  dma_we;
    logic [15:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [15:0] dma_rdata;
    logic        dma_starve;
    logic [9:0]  dmem_addr;
    logic        dmem_cen;
    logic [15:0] dmem_din;
    logic [1:0]  dmem_wen;
    logic [15:0] dmem_dout;

    logic [15:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter #(.AW(10), .STARVE_MAX(8)) dut (
        .mclk          (mclk),
        .puc_rst       (puc_rst),
        .cpu_dmem_addr (cpu_dmem_addr),
        .cpu_dmem_cen  (cpu_dmem_cen),
        .cpu_dmem_din  (cpu_dmem_din),
        .cpu_dmem_wen  (cpu_dmem_wen),
        .cpu_dmem_dout (cpu_dmem_dout),
        .dma_req       (dma_req),
        .dma_addr      (dma_addr),
        .dma_we        (dma_we),
        .dma_wdata     (dma_wdata),
        .dma_gnt       (dma_gnt),
        .dma_rvalid    (dma_rvalid),
        .dma_rdata     (dma_rdata),
        .dma_starve    (dma_starve),
        .dmem_addr     (dmem_addr),
        .dmem_cen      (dmem_cen),
        .dmem_din      (dmem_din),
        .dmem_wen      (dmem_wen),
        .dmem_dout     (dmem_dout)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Single-port memory model: low-active enables, one-cycle registered read.
    always @(posedge mclk) begin
        if (!dmem_cen) begin
            if (!dmem_wen[0]) mem[dmem_addr][7:0]  <= dmem_din[7:0];
            if (!dmem_wen[1]) mem[dmem_addr][15:8] <= dmem_din[15:8];
            dmem_dout <= mem[dmem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        cpu_cen;
        logic [9:0]  cpu_addr;
        logic [15:0] cpu_din;
        logic [1:0]  cpu_wen;
        logic        req;
        logic [9:0]  d_addr;
        logic [1:0]  d_we;
        logic [15:0] d_wdata;
        logic        e_gnt;
        logic        e_cen;
        logic [9:0]  e_addr;
        logic [15:0] e_din;
        logic [1:0]  e_wen;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic settle();
        @(negedge mclk);
    endtask

    task automatic idle();
        cpu_dmem_cen = 1'b1;
        cpu_dmem_wen = 2'b11;
        dma_req      = 1'b0;
        dma_we       = 2'b00;
    endtask

    task automatic cpu_wr(input logic [9:0] a, input logic [15:0] d);
        cpu_dmem_cen  = 1'b0;
        cpu_dmem_addr = a;
        cpu_dmem_din  = d;
        cpu_dmem_wen  = 2'b00;
        tick();
        idle();
        $display("preload mem[%h] = %h", a, d);
    endtask

    initial begin
        puc_rst       = 1'b1;
        cpu_dmem_addr = '0;
        cpu_dmem_din  = '0;
        dma_addr      = '0;
        dma_wdata     = '0;
        idle();
        tick();
        tick();

        settle();
        $display("reset state");
        check("rst_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_rdata",  32'(dma_rdata),  32'h0000);
        check("rst_starve", 32'(dma_starve), 32'd0);
        check("rst_cen",    32'(dmem_cen),   32'd1);

        //                rst cen addr    din       wen    req daddr   dwe    dwdata    gnt cen eaddr   edin      ewen
        vecs[0] = '{1'b1, 1'b0, 10'h201, 16'h1111, 2'b00, 1'b1, 10'h3F0, 2'b00, 16'h2222, 1'b0, 1'b1, 10'h201, 16'h1111, 2'b11};
        vecs[1] = '{1'b1, 1'b1, 10'h202, 16'h3333, 2'b11, 1'b1, 10'h3F1, 2'b11, 16'h4444, 1'b0, 1'b1, 10'h202, 16'h3333, 2'b11};
        vecs[2] = '{1'b0, 1'b1, 10'h155, 16'h1357, 2'b00, 1'b0, 10'h3F2, 2'b11, 16'h5555, 1'b0, 1'b1, 10'h155, 16'h1357, 2'b11};
        vecs[3] = '{1'b0, 1'b0, 10'h2AA, 16'h2468, 2'b11, 1'b0, 10'h3F3, 2'b11, 16'h6666, 1'b0, 1'b0, 10'h2AA, 16'h2468, 2'b11};
        vecs[4] = '{1'b0, 1'b0, 10'h2AB, 16'h9876, 2'b01, 1'b1, 10'h3FF, 2'b11, 16'h7777, 1'b0, 1'b0, 10'h2AB, 16'h9876, 2'b01};
        vecs[5] = '{1'b0, 1'b1, 10'h2AC, 16'h0F00, 2'b00, 1'b1, 10'h3FF, 2'b11, 16'hA5A5, 1'b1, 1'b0, 10'h3FF, 16'hA5A5, 2'b00};
        vecs[6] = '{1'b0, 1'b1, 10'h2AD, 16'h00F0, 2'b00, 1'b1, 10'h3FE, 2'b01, 16'h5A5A, 1'b1, 1'b0, 10'h3FE, 16'h5A5A, 2'b10};
        vecs[7] = '{1'b0, 1'b1, 10'h2AE, 16'h000F, 2'b11, 1'b1, 10'h3FD, 2'b10, 16'hC3C3, 1'b1, 1'b0, 10'h3FD, 16'hC3C3, 2'b01};

        for (int i = 0; i < 8; i++) begin
            puc_rst       = vecs[i].rst;
            cpu_dmem_cen  = vecs[i].cpu_cen;
            cpu_dmem_addr = vecs[i].cpu_addr;
            cpu_dmem_din  = vecs[i].cpu_din;
            cpu_dmem_wen  = vecs[i].cpu_wen;
            dma_req       = vecs[i].req;
            dma_addr      = vecs[i].d_addr;
            dma_we        = vecs[i].d_we;
            dma_wdata     = vecs[i].d_wdata;
            settle();
            $display("vector %0d: rst=%b cen=%b req=%b -> gnt=%b cen=%b addr=%h din=%h wen=%b",
                     i, puc_rst, cpu_dmem_cen, dma_req, dma_gnt, dmem_cen, dmem_addr, dmem_din, dmem_wen);
            check($sformatf("vec%0d_gnt", i),  32'(dma_gnt),   32'(vecs[i].e_gnt));
            check($sformatf("vec%0d_cen", i),  32'(dmem_cen),  32'(vecs[i].e_cen));
            check($sformatf("vec%0d_addr", i), 32'(dmem_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_din", i),  32'(dmem_din),  32'(vecs[i].e_din));
            check($sformatf("vec%0d_wen", i),  32'(dmem_wen),  32'(vecs[i].e_wen));
            tick();
        end

        puc_rst = 1'b1;
        idle();
        tick();
        puc_rst = 1'b0;
        tick();

        // CPU-only traffic
        cpu_dmem_cen = 1'b0; cpu_dmem_addr = 10'h010; cpu_dmem_wen = 2'b11;
        settle();
        $display("cpu read 010");
        check("t1_rd_addr", 32'(dmem_addr), 32'h010);
        check("t1_rd_cen",  32'(dmem_cen),  32'd0);
        check("t1_rd_wen",  32'(dmem_wen),  32'b11);
        check("t1_rd_gnt",  32'(dma_gnt),   32'd0);
        tick();
        cpu_dmem_din = 16'hBEEF; cpu_dmem_wen = 2'b00;
        settle();
        $display("cpu write 010 = beef");
        check("t1_wr_din", 32'(dmem_din), 32'hBEEF);
        check("t1_wr_wen", 32'(dmem_wen), 32'b00);
        tick();
        cpu_dmem_wen = 2'b11;
        tick();
        idle();
        settle();
        $display("cpu read 010 returns %h", cpu_dmem_dout);
        check("t1_dout", 32'(cpu_dmem_dout), 32'hBEEF);
        check("t1_idle_cen", 32'(dmem_cen), 32'd1);
        tick();

        // DMA read in an idle cycle
        cpu_wr(10'h020, 16'h1234);
        dma_req = 1'b1; dma_addr = 10'h020; dma_we = 2'b00;
        settle();
        $display("dma read 020 gnt=%b", dma_gnt);
        check("t2_gnt",    32'(dma_gnt),    32'd1);
        check("t2_addr",   32'(dmem_addr),  32'h020);
        check("t2_wen",    32'(dmem_wen),   32'b11);
        check("t2_rv_n",   32'(dma_rvalid), 32'd0);
        tick();
        dma_req = 1'b0;
        settle();
        check("t2_rv_n1",  32'(dma_rvalid), 32'd1);
        tick();
        settle();
        $display("dma read 020 data %h", dma_rdata);
        check("t2_rv_n2",  32'(dma_rvalid), 32'd0);
        check("t2_rdata",  32'(dma_rdata),  32'h1234);
        tick();

        // Contention and starvation
        cpu_dmem_cen = 1'b0; cpu_dmem_addr = 10'h100; cpu_dmem_wen = 2'b11;
        dma_req = 1'b1; dma_addr = 10'h030; dma_we = 2'b11; dma_wdata = 16'h5A5A;
        for (int k = 0; k < 10; k++) begin
            settle();
            $display("contention cycle %0d gnt=%b starve=%b", k, dma_gnt, dma_starve);
            check($sformatf("t3_gnt%0d", k),    32'(dma_gnt),    32'd0);
            check($sformatf("t3_starve%0d", k), 32'(dma_starve), (k >= 8) ? 32'd1 : 32'd0);
            tick();
        end
        cpu_dmem_cen = 1'b1;
        settle();
        $display("contention released gnt=%b", dma_gnt);
        check("t3_gnt_free", 32'(dma_gnt),    32'd1);
        check("t3_starve_g", 32'(dma_starve), 32'd1);
        check("t3_wen",      32'(dmem_wen),   32'b00);
        check("t3_din",      32'(dmem_din),   32'h5A5A);
        tick();
        dma_req = 1'b0;
        settle();
        check("t3_starve_clr", 32'(dma_starve), 32'd0);
        check("t3_mem",        32'(mem[10'h030]), 32'h5A5A);
        tick();

        // DMA byte write
        cpu_wr(10'h040, 16'h1111);
        dma_req = 1'b1; dma_addr = 10'h040; dma_we = 2'b10; dma_wdata = 16'hAB00;
        settle();
        $display("dma byte write 040 wen=%b", dmem_wen);
        check("t4_gnt", 32'(dma_gnt),  32'd1);
        check("t4_wen", 32'(dmem_wen), 32'b01);
        tick();
        dma_req = 1'b0;
        settle();
        check("t4_mem",   32'(mem[10'h040]), 32'hAB11);
        check("t4_no_rv", 32'(dma_rvalid),   32'd0);
        tick();

        // CPU read then DMA read interleaved
        cpu_wr(10'h050, 16'hCAFE);
        cpu_wr(10'h060, 16'h0F0F);
        cpu_dmem_cen = 1'b0; cpu_dmem_addr = 10'h050; cpu_dmem_wen = 2'b11;
        tick();
        cpu_dmem_cen = 1'b1;
        dma_req = 1'b1; dma_addr = 10'h060; dma_we = 2'b00;
        settle();
        $display("interleave N+1 cpu_dout=%h rvalid=%b", cpu_dmem_dout, dma_rvalid);
        check("t5_cpu_dout", 32'(cpu_dmem_dout), 32'hCAFE);
        check("t5_rv_n1",    32'(dma_rvalid),    32'd0);
        check("t5_gnt",      32'(dma_gnt),       32'd1);
        tick();
        dma_req = 1'b0;
        settle();
        check("t5_rv_n2",   32'(dma_rvalid),    32'd1);
        check("t5_dout_n2", 32'(dmem_dout),     32'h0F0F);
        tick();
        settle();
        $display("interleave N+3 rdata=%h", dma_rdata);
        check("t5_rdata",   32'(dma_rdata),  32'h0F0F);
        check("t5_rv_n3",   32'(dma_rvalid), 32'd0);
        tick();

        // Back-to-back DMA reads
        dma_req = 1'b1; dma_addr = 10'h020; dma_we = 2'b00;
        settle();
        check("bb_gnt0", 32'(dma_gnt), 32'd1);
        tick();
        dma_addr = 10'h050;
        settle();
        check("bb_gnt1", 32'(dma_gnt),    32'd1);
        check("bb_rv1",  32'(dma_rvalid), 32'd1);
        tick();
        dma_req = 1'b0;
        settle();
        $display("back-to-back first data %h", dma_rdata);
        check("bb_rv2",    32'(dma_rvalid), 32'd1);
        check("bb_rdata1", 32'(dma_rdata),  32'h1234);
        tick();
        settle();
        $display("back-to-back second data %h", dma_rdata);
        check("bb_rv3",    32'(dma_rvalid), 32'd0);
        check("bb_rdata2", 32'(dma_rdata),  32'hCAFE);
        tick();

        // Reset in the middle of a DMA read
        cpu_wr(10'h070, 16'h7777);
        dma_req = 1'b1; dma_addr = 10'h070; dma_we = 2'b00;
        settle();
        check("t6_gnt", 32'(dma_gnt), 32'd1);
        tick();
        puc_rst = 1'b1;
        cpu_dmem_cen = 1'b0;
        settle();
        $display("reset mid-read rvalid=%b cen=%b", dma_rvalid, dmem_cen);
        check("t6_rv_rst",  32'(dma_rvalid), 32'd0);
        check("t6_cen_rst", 32'(dmem_cen),   32'd1);
        check("t6_gnt_rst", 32'(dma_gnt),    32'd0);
        tick();
        settle();
        check("t6_rdata_rst", 32'(dma_rdata),  32'h0000);
        check("t6_starve",    32'(dma_starve), 32'd0);
        check("t6_cen_rst2",  32'(dmem_cen),   32'd1);
        tick();
        puc_rst = 1'b0;
        idle();
        settle();
        check("t6_no_pulse", 32'(dma_rvalid), 32'd0);
        check("t6_rdata",    32'(dma_rdata),  32'h0000);
        tick();

        // Counter cleared by reset
        cpu_dmem_cen = 1'b0; cpu_dmem_addr = 10'h100; cpu_dmem_wen = 2'b11;
        dma_req = 1'b1; dma_we = 2'b00;
        for (int k = 0; k < 9; k++) tick();
        settle();
        check("cr_starve_set", 32'(dma_starve), 32'd1);
        tick();
        puc_rst = 1'b1;
        tick();
        puc_rst = 1'b0;
        settle();
        $display("starve after reset %b", dma_starve);
        check("cr_starve_clr", 32'(dma_starve), 32'd0);
        tick();
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (16-bit word, low-active chip enable, low-active byte write enables, 1-cycle registered read) between the openMSP430 CPU port and a DMA/loader master.
- The CPU has absolute priority because it has no wait input. DMA uses only the cycles the CPU leaves idle.
- Sits between the core's dmem_* pins and the memory macro. Owns read-data routing and DMA starvation monitoring.

Parameters:
- AW, 10, word-address width (equals DMEM_MSB+1).
- STARVE_MAX, 8, consecutive blocked DMA cycles before dma_starve asserts (range 1..255).

Ports:
- mclk  in  1  system clock.
- puc_rst  in  1  synchronous active-high reset.
- cpu_dmem_addr  in  AW  CPU word address.
- cpu_dmem_cen  in  1  CPU chip enable, low active.
- cpu_dmem_din  in  16  CPU write data.
- cpu_dmem_wen  in  2  CPU byte write enables, low active.
- cpu_dmem_dout  out  16  read data to CPU.
- dma_req  in  1  DMA access request, held until granted.
- dma_addr  in  AW  DMA word address.
- dma_we  in  2  DMA byte write enables, high active (00 = read).
- dma_wdata  in  16  DMA write data.
- dma_gnt  out  1  DMA access issued this cycle (combinational).
- dma_rvalid  out  1  one-cycle pulse: dma_rdata holds new read data.
- dma_rdata  out  16  captured DMA read data.
- dma_starve  out  1  DMA blocked for STARVE_MAX or more consecutive cycles.
- dmem_addr  out  AW  memory address.
- dmem_cen  out  1  memory chip enable, low active.
- dmem_din  out  16  memory write data.
- dmem_wen  out  2  memory byte write enables, low active.
- dmem_dout  in  16  memory read data, valid the cycle after a read.

Behaviour:
- Clock is mclk. Reset is puc_rst, synchronous, active-high. All state is sampled on the rising edge of mclk.

Arbitration (combinational, per cycle):
- cpu_dmem_cen=0: the CPU drives dmem_addr, dmem_din and dmem_wen unchanged; dmem_cen=0; dma_gnt=0.
- cpu_dmem_cen=1 and dma_req=1: dma_gnt=1; dmem_addr=dma_addr; dmem_din=dma_wdata; dmem_wen=~dma_we; dmem_cen=0.
- Neither requesting: dmem_cen=1, dmem_wen=11, dmem_addr and dmem_din = CPU values (hold, no toggling).
- Simultaneous CPU and DMA request: the CPU always wins. The DMA request stays pending with no loss and no duplicate issue.

Read routing (state register rd_owner, values NONE/CPU/DMA):
- Next value: CPU if the CPU issued a read (cen=0, wen=11); DMA if the DMA was granted with dma_we=00; otherwise NONE.
- Writes, including partial byte writes, set rd_owner=NONE.
- cpu_dmem_dout = dmem_dout always, as a pass-through. The CPU only samples it after its own read, so no masking is needed.
- rd_owner==DMA: dma_rdata <= dmem_dout and dma_rvalid=1 for exactly one cycle. Otherwise dma_rvalid=0 and dma_rdata holds its value.
- Read latency for DMA: grant in cycle N, dma_rvalid and data in cycle N+1 (registered capture of the N+1 dout; visible to the DMA from N+2 as dma_rdata). dma_rvalid itself is asserted during cycle N+1, derived from rd_owner.
- Back-to-back DMA reads are supported at full rate, giving one rvalid per grant.

Starvation counter (8-bit, saturating at STARVE_MAX):
- Increments when dma_req=1 and dma_gnt=0.
- Clears when dma_gnt=1 or dma_req=0.
- dma_starve = (count==STARVE_MAX), registered.
- Deasserts the cycle after the grant.

Reset values:
- rd_owner=NONE, dma_rvalid=0, dma_rdata=0000, counter=0, dma_starve=0.
- During reset: dma_gnt forced 0 and dmem_cen=1 regardless of inputs, so no memory access occurs while puc_rst=1.
- Reset mid-read: a pending rvalid is dropped, with no pulse after reset.

Boundary conditions:
- Address wrap is not applicable; addresses pass through unmodified at AW bits.
- A DMA write with dma_we=00 is a read by definition.

Decomposition:
- Shared package: rd_owner encoding constants (NONE=2'd0, CPU=2'd1, DMA=2'd2) and the STARVE counter width. Place these in the existing openMSP430 defines file as ``define``s, consistent with DMEM_MSB usage.
- No sub-module. The starvation counter is small enough to stay inline.

Test Plan:
1. CPU-only traffic: CPU read at 0x010, then a write of 0xBEEF with wen=00 at 0x010, then a read -> dmem pins mirror the CPU port exactly; cpu_dmem_dout=0xBEEF one cycle after the second read; dma_gnt stays 0.
2. DMA read in idle cycles: preload 0x1234 at 0x020; dma_req with dma_we=00, addr 0x020 while CPU idle -> dma_gnt same cycle, dma_rvalid pulse next cycle, dma_rdata=0x1234.
3. Contention: CPU reads every cycle for 10 cycles while DMA holds a request to write 0x5A5A to 0x030 -> no grant during those 10 cycles; dma_starve rises after 8 blocked cycles; grant on the first CPU-idle cycle; memory at 0x030 = 0x5A5A; dma_starve clears the next cycle.
4. Byte write: DMA dma_we=10, wdata 0xAB00, addr 0x040 preloaded 0x1111 -> dmem_wen=01; memory becomes 0xAB11.
5. Interleave: CPU read of 0x050 (0xCAFE) in cycle N, DMA read of 0x060 (0x0F0F) in N+1 -> cpu_dmem_dout=0xCAFE at N+1; dma_rvalid only at N+2 with 0x0F0F; no rvalid at N+1.
6. Reset mid-operation: DMA read granted, puc_rst=1 in the next cycle -> dma_rvalid=0, dma_rdata=0000, dmem_cen=1 throughout reset, counter=0.
